knn_feeder: RTL

//  Native-bus initiator that drives the KNN peripheral's slave port on behalf of a datapath.
//  Per job: soft-resets the neighbour list, writes the test point, streams N labelled training points
//  (B, LABEL, ENABLE pulse each), then reads back the K neighbour-info words onto a result stream.

---
 rtl/knn_feeder_pkg.sv | 28 ++
 rtl/knn_feeder_nat_master.sv | 68 ++++++
 rtl/knn_feeder.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/knn_feeder_pkg.sv
// Shared definitions for knn_feeder: KNN peripheral register map, default K, and FSM states.
package knn_feeder_pkg;

  localparam int unsigned REG_RESET  = 0;
  localparam int unsigned REG_ENABLE = 1;
  localparam int unsigned REG_A      = 2;
  localparam int unsigned REG_B      = 3;
  localparam int unsigned REG_LABEL  = 4;
  localparam int unsigned REG_INFO0  = 5;

  localparam int unsigned K_DEFAULT  = 10;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RST1,
    S_RST0,
    S_WR_A,
    S_WAIT_PT,
    S_WR_B,
    S_WR_LBL,
    S_EN1,
    S_EN0,
    S_RD_INFO,
    S_RES,
    S_DONE
  } state_t;

endpackage

// File: rtl/knn_feeder_nat_master.sv
// Single-transaction native-bus initiator with one-cycle turnaround.
// Optional bus watchdog enabled by KNN_FEEDER_TIMEOUT_EN.
module knn_feeder_nat_master #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int TMO_W  = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic                  i_we,
  input  logic [ADDR_W-1:0]     i_addr,
  input  logic [DATA_W-1:0]     i_wdata,
  output logic                  o_ack,
  output logic                  o_timeout,
  output logic                  m_valid,
  output logic [ADDR_W-1:0]     m_addr,
  output logic [DATA_W-1:0]     m_wdata,
  output logic [DATA_W/8-1:0]   m_wstrb,
  input  logic                  m_ready
);

  logic                r_valid;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W/8-1:0] r_wstrb;
  logic                w_tmo;

`ifdef KNN_FEEDER_TIMEOUT_EN
  logic [TMO_W-1:0] r_tmo;

  // Fires on the (2^TMO_W-1)th consecutive cycle of m_valid without m_ready.
  assign w_tmo = r_valid && !m_ready && (r_tmo == TMO_W'((2 ** TMO_W) - 2));

  always_ff @(posedge clk) begin
    if (rst || !r_valid || m_ready) r_tmo <= '0;
    else                            r_tmo <= r_tmo + TMO_W'(1);
  end
`else
  assign w_tmo = 1'b0;
`endif

  // Dropping r_valid on completion guarantees one idle cycle; a request
  // seen in that cycle launches on the following one.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
    end else if (r_valid) begin
      if (m_ready || w_tmo) r_valid <= 1'b0;
    end else if (i_req) begin
      r_valid <= 1'b1;
      r_addr  <= i_addr;
      r_wdata <= i_we ? i_wdata : '0;
      r_wstrb <= i_we ? '1 : '0;
    end
  end

  assign o_ack     = r_valid && m_ready;
  assign o_timeout = w_tmo;
  assign m_valid   = r_valid;
  assign m_addr    = r_addr;
  assign m_wdata   = r_wdata;
  assign m_wstrb   = r_wstrb;

endmodule

// File: rtl/knn_feeder.sv
// Job sequencer driving the KNN peripheral: reset, test point, N training points, K info reads.
// Bus watchdog and sticky err are enabled by KNN_FEEDER_TIMEOUT_EN.
module knn_feeder
  import knn_feeder_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32,
  parameter int LABEL_W = 8,
  parameter int NPTS_W  = 16,
  parameter int K       = K_DEFAULT,
  parameter int TMO_W   = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [DATA_W-1:0]   cmd_test,
  input  logic [NPTS_W-1:0]   cmd_npts,
  input  logic                pt_valid,
  output logic                pt_ready,
  input  logic [DATA_W-1:0]   pt_data,
  input  logic [LABEL_W-1:0]  pt_label,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [DATA_W-1:0]   res_data,
  output logic                res_last,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic                m_valid,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic                m_ready
);

  localparam int IDX_W = (K > 1) ? $clog2(K) : 1;

  state_t              r_state, w_next;
  logic [DATA_W-1:0]   r_test, r_pt, r_res;
  logic [NPTS_W-1:0]   r_npts, r_cnt;
  logic [LABEL_W-1:0]  r_lbl;
  logic [IDX_W-1:0]    r_idx;

  logic                w_req, w_we, w_ack, w_tmo;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_wdata;
  logic                w_last_pt, w_last_info;

  assign w_last_pt   = (r_cnt == r_npts - NPTS_W'(1));
  assign w_last_info = (r_idx == IDX_W'(K - 1));

  knn_feeder_nat_master #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TMO_W  (TMO_W)
  ) u_nat (
    .clk       (clk),
    .rst       (rst),
    .i_req     (w_req),
    .i_we      (w_we),
    .i_addr    (w_addr),
    .i_wdata   (w_wdata),
    .o_ack     (w_ack),
    .o_timeout (w_tmo),
    .m_valid   (m_valid),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_wstrb   (m_wstrb),
    .m_ready   (m_ready)
  );

  always_comb begin
    w_next  = r_state;
    w_req   = 1'b0;
    w_we    = 1'b1;
    w_addr  = '0;
    w_wdata = '0;
    case (r_state)
      S_IDLE:    if (cmd_valid) w_next = S_RST1;
      S_RST1: begin
        w_req = 1'b1; w_addr = ADDR_W'(REG_RESET); w_wdata = DATA_W'(1);
        if (w_ack) w_next = S_RST0;
      end
      S_RST0: begin
        w_req = 1'b1; w_addr = ADDR_W'(REG_RESET);
        if (w_ack) w_next = S_WR_A;
      end
      S_WR_A: begin
        w_req = 1'b1; w_addr = ADDR_W'(REG_A); w_wdata = r_test;
        if (w_ack) w_next = (r_npts == '0) ? S_RD_INFO : S_WAIT_PT;
      end
      S_WAIT_PT: if (pt_valid) w_next = S_WR_B;
      S_WR_B: begin
        w_req = 1'b1; w_addr = ADDR_W'(REG_B); w_wdata = r_pt;
        if (w_ack) w_next = S_WR_LBL;
      end
      S_WR_LBL: begin
        w_req = 1'b1; w_addr = ADDR_W'(REG_LABEL); w_wdata = DATA_W'(r_lbl);
        if (w_ack) w_next = S_EN1;
      end
      S_EN1: begin
        w_req = 1'b1; w_addr = ADDR_W'(REG_ENABLE); w_wdata = DATA_W'(1);
        if (w_ack) w_next = S_EN0;
      end
      S_EN0: begin
        w_req = 1'b1; w_addr = ADDR_W'(REG_ENABLE);
        if (w_ack) w_next = w_last_pt ? S_RD_INFO : S_WAIT_PT;
      end
      S_RD_INFO: begin
        w_req = 1'b1; w_we = 1'b0;
        w_addr = ADDR_W'(REG_INFO0) + ADDR_W'(r_idx);
        if (w_ack) w_next = S_RES;
      end
      S_RES:     if (res_ready) w_next = w_last_info ? S_DONE : S_RD_INFO;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
    if (w_tmo) w_next = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_test  <= '0;
      r_npts  <= '0;
      r_cnt   <= '0;
      r_pt    <= '0;
      r_lbl   <= '0;
      r_idx   <= '0;
      r_res   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && cmd_valid) begin
        r_test <= cmd_test;
        r_npts <= cmd_npts;
        r_cnt  <= '0;
        r_idx  <= '0;
      end
      if (r_state == S_WAIT_PT && pt_valid) begin
        r_pt  <= pt_data;
        r_lbl <= pt_label;
      end
      if (r_state == S_EN0 && w_ack && !w_last_pt) r_cnt <= r_cnt + NPTS_W'(1);
      if (r_state == S_RD_INFO && w_ack)           r_res <= m_rdata;
      if (r_state == S_RES && res_ready && !w_last_info) r_idx <= r_idx + IDX_W'(1);
    end
  end

`ifdef KNN_FEEDER_TIMEOUT_EN
  logic r_err;
  always_ff @(posedge clk) begin
    if (rst)                                r_err <= 1'b0;
    else if (r_state == S_IDLE && cmd_valid) r_err <= 1'b0;
    else if (w_tmo)                          r_err <= 1'b1;
  end
  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  assign cmd_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign pt_ready  = (r_state == S_WAIT_PT) && pt_valid;
  assign res_valid = (r_state == S_RES);
  assign res_data  = (r_state == S_RES) ? r_res : '0;
  assign res_last  = (r_state == S_RES) && w_last_info;

endmodule
